// File: rtl/fme_half_sad_sel.sv
// Half-pel SAD accumulator and best-candidate selector for the FME pipeline.
// Nine SADs are built over one block, then scanned centre-first to pick the winner.
module fme_half_sad_sel #(
    parameter int BLK_PIX = 16,
    parameter int SAD_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0][7:0]  half,
    input  logic [7:0]       cur_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       best_idx,
    output logic [SAD_W-1:0] best_sad
);
    localparam int CNT_W = (BLK_PIX > 2) ? $clog2(BLK_PIX) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLK_PIX - 1);

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_CMP = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [3:0]        cmp_step_q, cmp_step_d;
    logic [SAD_W-1:0]  sad_acc_q [0:8];
    logic [SAD_W-1:0]  sad_acc_d [0:8];
    logic [3:0]        best_idx_q, best_idx_d;
    logic [SAD_W-1:0]  best_sad_q, best_sad_d;
    logic              out_valid_q, out_valid_d;
    logic              transfer_s;
    logic [3:0]        cand_idx_s;
    logic [SAD_W-1:0]  cand_sad_s;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Centre first so that ties resolve to the integer-pel position.
    function automatic logic [3:0] scan_idx(input logic [3:0] step);
        logic [3:0] idx;
        if (step == 4'd0) begin
            idx = 4'd4;
        end else if (step <= 4'd4) begin
            idx = step - 4'd1;
        end else begin
            idx = step;
        end
        return idx;
    endfunction

    assign in_ready   = (state_q == ST_ACC);
    assign transfer_s = in_valid && (state_q == ST_ACC);
    assign cand_idx_s = scan_idx(cmp_step_q);
    assign cand_sad_s = sad_acc_q[cand_idx_s];
    assign out_valid  = out_valid_q;
    assign best_idx   = best_idx_q;
    assign best_sad   = best_sad_q;

    // Next-state logic for accumulation, scan and handshake.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        cmp_step_d  = cmp_step_q;
        sad_acc_d   = sad_acc_q;
        best_idx_d  = best_idx_q;
        best_sad_d  = best_sad_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_ACC: begin
                if (transfer_s) begin
                    for (int i = 0; i < 9; i++) begin
                        sad_acc_d[i] = sad_acc_q[i] + SAD_W'(abs_diff(half[i], cur_pix));
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = ST_CMP;
                        cmp_step_d = 4'd0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_CMP: begin
                if (cmp_step_q == 4'd0) begin
                    best_idx_d = cand_idx_s;
                    best_sad_d = cand_sad_s;
                end else if (cand_sad_s < best_sad_q) begin
                    best_idx_d = cand_idx_s;
                    best_sad_d = cand_sad_s;
                end else begin
                    best_idx_d = best_idx_q;
                end
                if (cmp_step_q == 4'd8) begin
                    state_d     = ST_OUT;
                    out_valid_d = 1'b1;
                end else begin
                    cmp_step_d = cmp_step_q + 4'd1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d     = ST_ACC;
                    out_valid_d = 1'b0;
                    beat_cnt_d  = '0;
                    for (int i = 0; i < 9; i++) begin
                        sad_acc_d[i] = '0;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d     = ST_ACC;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_ACC;
            beat_cnt_q  <= '0;
            cmp_step_q  <= 4'd0;
            best_idx_q  <= 4'd4;
            best_sad_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                sad_acc_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            cmp_step_q  <= cmp_step_d;
            best_idx_q  <= best_idx_d;
            best_sad_q  <= best_sad_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < 9; i++) begin
                sad_acc_q[i] <= sad_acc_d[i];
            end
        end
    end
endmodule
